// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, {hi,lo} result.
// Latency: ready_o after WIDTH+2 edges from accept, 2 edges for divide by zero.
// Backpressure: result held in DONE until start_i is seen low; annul_i aborts BUSY/FIX.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [1:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 div_by_zero_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 is_sgn;
    logic                 sgn_a;
    logic                 sgn_b;
    logic                 dz;
    logic                 fix_ph;
    logic [WIDTH-1:0]     a_raw;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   fix_res;

    logic                 op1_neg;
    logic                 op2_neg;
    logic [WIDTH-1:0]     op1_mag;
    logic [WIDTH-1:0]     op2_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     quo_c;
    logic [WIDTH-1:0]     rem_c;
    logic [2*WIDTH-1:0]   prod_c;
    logic [2*WIDTH-1:0]   res_corr;

    always_comb begin
        op1_neg = op_i[0] & opdata1_i[WIDTH-1];
        op2_neg = op_i[0] & opdata2_i[WIDTH-1];
        op1_mag = op1_neg ? -opdata1_i : opdata1_i;
        op2_mag = op2_neg ? -opdata2_i : opdata2_i;
    end

    // acc is {hi,lo}: mul keeps the multiplier in lo and shifts the partial product in from the top;
    // div keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff = div_sh - {1'b0, b_mag};
        if (!is_div) begin
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        end else if (div_diff[WIDTH]) begin
            acc_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    always_comb begin
        quo_c  = (is_sgn && (sgn_a ^ sgn_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_c  = (is_sgn && sgn_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        prod_c = (is_sgn && (sgn_a ^ sgn_b)) ? -acc : acc;
        if (dz) begin
            res_corr = {a_raw, {WIDTH{1'b1}}};
        end else if (is_div) begin
            res_corr = {rem_c, quo_c};
        end else begin
            res_corr = prod_c;
        end
    end

    // FIX spends one cycle registering the sign-corrected value so the 2*WIDTH negate
    // never sits in front of result_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            is_div        <= 1'b0;
            is_sgn        <= 1'b0;
            sgn_a         <= 1'b0;
            sgn_b         <= 1'b0;
            dz            <= 1'b0;
            fix_ph        <= 1'b0;
            a_raw         <= '0;
            a_mag         <= '0;
            b_mag         <= '0;
            acc           <= '0;
            fix_res       <= '0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        is_div        <= op_i[1];
                        is_sgn        <= op_i[0];
                        sgn_a         <= op1_neg;
                        sgn_b         <= op2_neg;
                        a_raw         <= opdata1_i;
                        a_mag         <= op1_mag;
                        b_mag         <= op2_mag;
                        acc           <= {{WIDTH{1'b0}}, (op_i[1] ? op1_mag : op2_mag)};
                        cnt           <= '0;
                        fix_ph        <= 1'b0;
                        div_by_zero_o <= 1'b0;
                        if (op_i[1] && (opdata2_i == '0)) begin
                            dz    <= 1'b1;
                            state <= S_FIX;
                        end else begin
                            dz    <= 1'b0;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (annul_i) begin
                        state <= S_IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (annul_i) begin
                        fix_ph <= 1'b0;
                        state  <= S_IDLE;
                    end else if (!fix_ph) begin
                        fix_res <= res_corr;
                        fix_ph  <= 1'b1;
                    end else begin
                        result_o      <= fix_res;
                        div_by_zero_o <= dz;
                        fix_ph        <= 1'b0;
                        state         <= S_DONE;
                    end
                end
                default: begin
                    if (annul_i || !start_i) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready_o = (state == S_DONE);
    assign busy_o  = (state == S_BUSY) || (state == S_FIX);

endmodule
